// File: rtl/max_min_avg_pkg.sv
// rtl/max_min_avg_pkg.sv - shared state encoding and width defaults for max_min_avg_ctrl
package max_min_avg_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int LOG2_N_DEFAULT = 3;
    localparam int ACC_W_DEFAULT  = DATA_W_DEFAULT + LOG2_N_DEFAULT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/avg_accumulator.sv
// rtl/avg_accumulator.sv - block sum accumulator with floor or round-half-up (ROUND_AVG_EN) average
module avg_accumulator
    import max_min_avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LOG2_N = LOG2_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] avg_next
);

    localparam int ACC_W = DATA_W + LOG2_N;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] final_sum;

    // Sum including the sample presented this cycle, so the last accept sees the full block
    assign final_sum = acc_q + ACC_W'(in_data);

`ifdef ROUND_AVG_EN
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
    assign avg_next = DATA_W'((final_sum + HALF) >> LOG2_N);
`else
    assign avg_next = DATA_W'(final_sum >> LOG2_N);
`endif

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = final_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/max_min_avg_ctrl.sv
// rtl/max_min_avg_ctrl.sv - block sequencer driving external Max/Min registers; avg rounding via ROUND_AVG_EN
module max_min_avg_ctrl
    import max_min_avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LOG2_N = LOG2_N_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [DATA_W-1:0] max_q,
    input  logic [DATA_W-1:0] min_q,
    output logic              max_load,
    output logic              min_load,
    output logic [DATA_W-1:0] max_d,
    output logic [DATA_W-1:0] min_d,
    output logic [DATA_W-1:0] avg_out,
    output logic              busy,
    output logic              done
);

    localparam logic [LOG2_N-1:0] LAST = '1;

    state_t            state_q, state_d;
    logic [LOG2_N-1:0] count_q, count_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              first;
    logic              acc_clear;
    logic [DATA_W-1:0] avg_next;

    assign accept = in_valid & in_ready_q;
    assign first  = (count_q == '0);

    // The first sample always loads both registers so stale contents never survive a block
    assign max_load = accept & (first | (in_data > max_q));
    assign min_load = accept & (first | (in_data < min_q));
    assign max_d    = in_data;
    assign min_d    = in_data;

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign avg_out  = avg_q;

    avg_accumulator #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_acc (
        .clk      (CLK),
        .rst_n    (RESET),
        .clear    (acc_clear),
        .add      (accept),
        .in_data  (in_data),
        .avg_next (avg_next)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        avg_d     = avg_q;
        acc_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    count_d   = '0;
                    acc_clear = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    count_d = count_q + LOG2_N'(1);
                    if (count_q == LAST) begin
                        avg_d   = avg_next;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status outputs are decoded from the next state so they leave flops cleanly
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            count_q    <= '0;
            avg_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            avg_q      <= avg_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_max_min_avg_ctrl.sv
// tb/tb_max_min_avg_ctrl.sv - scoreboard bench for max_min_avg_ctrl with modelled Max/Min registers
module tb_max_min_avg_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       max_load, min_load;
    logic [7:0] max_d, min_d, avg_out;
    logic       busy, done;
    logic [7:0] max_reg = 8'hA5;
    logic [7:0] min_reg = 8'h5A;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int exp_done = 0;

    logic [1:0]  load_q[$];
    logic [23:0] res_q[$];
    logic [1:0]  exp_ld;
    logic [23:0] exp_res;
    logic [7:0]  blk[8];

    max_min_avg_ctrl dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .max_q    (max_reg),
        .min_q    (min_reg),
        .max_load (max_load),
        .min_load (min_load),
        .max_d    (max_d),
        .min_d    (min_d),
        .avg_out  (avg_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (max_load) max_reg <= max_d;
        if (min_load) min_reg <= min_d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            if (in_valid && in_ready) begin
                if (load_q.size() == 0) begin
                    check("load_queue_underflow", 32'd1, 32'd0);
                end else begin
                    exp_ld = load_q.pop_front();
                    check("max_load", 32'(max_load), 32'(exp_ld[1]));
                    check("min_load", 32'(min_load), 32'(exp_ld[0]));
                    check("max_d", 32'(max_d), 32'(in_data));
                    check("min_d", 32'(min_d), 32'(in_data));
                end
            end else begin
                check("no_strobe_without_accept", 32'({max_load, min_load}), 32'd0);
            end
            if (done) begin
                n_done++;
                if (res_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_res = res_q.pop_front();
                    check("avg_out", 32'(avg_out), 32'(exp_res[23:16]));
                    check("max_final", 32'(max_reg), 32'(exp_res[15:8]));
                    check("min_final", 32'(min_reg), 32'(exp_res[7:0]));
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic drive_sample(input logic [7:0] v, input logic ml, input logic nl,
                                input logic st, input int gap);
        int t;
        repeat (gap) begin
            @(posedge CLK); #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        start    = st;
        load_q.push_back({ml, nl});
        t = 0;
        @(negedge CLK);
        while (!in_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] s[8], input int gap,
                              input logic [7:0] mmask, input logic [7:0] nmask,
                              input logic [7:0] eavg, input logic [7:0] emax, input logic [7:0] emin,
                              input logic mid_start, input logic done_start);
        res_q.push_back({eavg, emax, emin});
        exp_done++;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            drive_sample(s[i], mmask[i], nmask[i], mid_start && (i == 4), gap);
        end
        start = done_start;
        @(negedge CLK);
        check("done_after_last_accept", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("ready_low_in_done", 32'(in_ready), 32'd0);
        @(posedge CLK); #1 start = 1'b0;
        @(negedge CLK);
        check("idle_ready_after_done", 32'(in_ready), 32'd0);
        check("idle_busy_after_done", 32'(busy), 32'd0);
        check("done_single_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_avg", 32'(avg_out), 32'd0);
        check("reset_loads", 32'({max_load, min_load}), 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;

        blk = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        send_block(blk, 0, 8'hFF, 8'h01, 8'd45, 8'd80, 8'd10, 1'b0, 1'b0);

        blk = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
`ifdef ROUND_AVG_EN
        send_block(blk, 0, 8'h03, 8'h01, 8'd2, 8'd2, 8'd1, 1'b0, 1'b0);
`else
        send_block(blk, 0, 8'h03, 8'h01, 8'd1, 8'd2, 8'd1, 1'b0, 1'b0);
`endif

        blk = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        send_block(blk, 0, 8'h01, 8'h01, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1);
        check("one_done_despite_starts", 32'(n_done), 32'(exp_done));

        blk = '{8'd50, 8'd30, 8'd90, 8'd30, 8'd90, 8'd10, 8'd60, 8'd40};
        send_block(blk, 3, 8'h05, 8'h23, 8'd50, 8'd90, 8'd10, 1'b0, 1'b0);

        pulse_start();
        drive_sample(8'd5, 1'b1, 1'b1, 1'b0, 0);
        drive_sample(8'd3, 1'b0, 1'b1, 1'b0, 0);
        drive_sample(8'd9, 1'b1, 1'b0, 1'b0, 0);
        drive_sample(8'd7, 1'b0, 1'b0, 1'b0, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_avg", 32'(avg_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("abort_no_done", 32'(n_done), 32'(exp_done));

        blk = '{8'd100, 8'd0, 8'd200, 8'd50, 8'd25, 8'd75, 8'd150, 8'd125};
`ifdef ROUND_AVG_EN
        send_block(blk, 0, 8'h05, 8'h03, 8'd91, 8'd200, 8'd0, 1'b0, 1'b0);
`else
        send_block(blk, 0, 8'h05, 8'h03, 8'd90, 8'd200, 8'd0, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("total_done_count", 32'(n_done), 32'(exp_done));
        check("result_queue_drained", 32'(res_q.size()), 32'd0);
        check("load_queue_drained", 32'(load_q.size()), 32'd0);
        check("final_avg_held", 32'(avg_out), 32'(res_q.size() == 0 ? exp_res[23:16] : 8'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
